cpu4_program_sequencer: RTL and testbench
=========================================

Name: cpu4_program_sequencer

Overview:
Controller that owns the 4-bit computer's program/data load port and its reset. On a start request it streams up to 16 instruction/data entries into the CPU memories and pads the unused slots with HLT. It then releases the CPU for a programmed number of cycles and captures the CPU output as the run result. It sits between a host/test driver and the CPU: it drives the CPU's ins_address, ins, d_in and rst pins, and observes d_out.

Parameters:
DEPTH, 16, number of memory slots written per load (fixed to the CPU's 4-bit address space)
PAD_INS, 8'h0F, instruction written to unused slots (HLT opcode, address field 0)
PAD_DATA, 4'h0, data written to unused slots

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous active-high reset
start  in  1  begin a load+run; sampled only in IDLE
abort  in  1  cancel the current load/run; returns to IDLE
load_count  in  5  number of user entries, latched on start; 0..16, values >16 clamp to 16
run_len  in  8  number of CPU run cycles, latched on start; 0 means 256
wr_valid  in  1  upstream entry valid
wr_ready  out  1  sequencer accepts an entry; equals (state==LOAD) & ~abort
wr_ins  in  8  instruction byte: [7:4] address/immediate, [3:0] opcode
wr_data  in  4  data word for the same slot
cpu_ins_address  out  4  slot index to the CPU
cpu_ins  out  8  instruction to the CPU
cpu_d_in  out  4  data to the CPU
cpu_rst  out  1  CPU reset; 1 in every state except RUN
cpu_d_out  in  4  CPU output observed
result  out  4  cpu_d_out captured at the end of RUN
done  out  1  one-cycle pulse in SAMPLE
busy  out  1  1 in every state except IDLE
aborted  out  1  sticky; set by abort, cleared by the next accepted start

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, cpu_rst=1, cpu_ins_address=0, cpu_ins=0, cpu_d_in=0, result=0, done=0, busy=0, aborted=0, and the internal index and run counter are cleared. Reset overrides start and abort.
- States: IDLE, LOAD, PAD, SETTLE, RUN, SAMPLE.
- IDLE: start=1 -> latch the clamped load_count and run_len, idx=0, aborted=0. Next state is LOAD if count>0, else PAD.
- LOAD: each accepted beat (wr_valid & wr_ready) registers cpu_ins_address=idx, cpu_ins=wr_ins, cpu_d_in=wr_data, then idx++.
  - Outputs are registered on posedge so they are stable at the CPU's negedge write.
  - No beat -> outputs and idx hold.
  - The beat that makes idx==count goes to SETTLE if count==16, else PAD.
- PAD: one slot per cycle: cpu_ins_address=idx, cpu_ins=PAD_INS, cpu_d_in=PAD_DATA, idx++. After slot 15 is driven, go to SETTLE.
- SETTLE: one cycle. Outputs hold so the last slot lands on the negedge. Load the run counter, then go to RUN.
- RUN: cpu_rst=0 for exactly run_len cycles (256 if 0). Write outputs hold at the last slot's values.
  - The CPU rewrites memory every negedge, so it must see identical content.
  - On the posedge ending the final RUN cycle: result <= cpu_d_out (pre-edge value), cpu_rst <= 1, go to SAMPLE.
- SAMPLE: done=1 for one cycle, then IDLE. start is ignored in SAMPLE.
- start while busy is ignored; there is no queuing.
- abort in LOAD/PAD/SETTLE/RUN: next state IDLE, cpu_rst=1, aborted=1, no done, result unchanged.
  - An entry offered in the same cycle as abort is not accepted, because wr_ready=0.
  - abort in IDLE or SAMPLE has no effect.
- rst mid-operation: identical to reset; aborted is not set.
- Counters: idx is 5-bit internally; cpu_ins_address = idx[3:0]. The run counter is 9-bit.

Test Plan:
1. Hold rst=1 for 2 cycles -> cpu_rst=1, busy=0, done=0, wr_ready=0, result=0, all cpu_* write outputs 0.
2. start with load_count=3, run_len=10, and back-to-back beats {8'h17,0},{8'h00,0},{8'h04,0} -> slots 0..2 written, slots 3..15 written 8'h0F/0. cpu_rst is low for exactly 10 cycles. result=4'h1. done pulses in cycle 28 after the start edge.
3. Same program with wr_valid toggling 1,0,0,1,0,1 -> cpu_ins_address advances only on accepted beats; same final result 4'h1; done delayed by exactly 3 cycles.
4. load_count=16 with 16 beats -> no PAD cycles; SETTLE directly after beat 16; load_count=20 behaves identically to 16.
5. abort asserted with the 2nd beat offered -> beat not accepted, state IDLE next cycle, aborted=1, cpu_rst=1, no done; the next start clears aborted.
6. run_len=0 -> cpu_rst low for exactly 256 cycles. A start pulse during RUN is ignored: exactly one done.

Source files
------------

// File: rtl/cpu4_program_sequencer.sv
// rtl/cpu4_program_sequencer.sv - loads program/data into the 4-bit CPU, runs it for a set number of cycles, captures its output
module cpu4_program_sequencer #(
    parameter int         DEPTH    = 16,
    parameter logic [7:0] PAD_INS  = 8'h0F,
    parameter logic [3:0] PAD_DATA = 4'h0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [4:0] load_count_i,
    input  logic [7:0] run_len_i,
    input  logic       wr_valid_i,
    output logic       wr_ready_o,
    input  logic [7:0] wr_ins_i,
    input  logic [3:0] wr_data_i,
    output logic [3:0] cpu_ins_address_o,
    output logic [7:0] cpu_ins_o,
    output logic [3:0] cpu_d_in_o,
    output logic       cpu_rst_o,
    input  logic [3:0] cpu_d_out_i,
    output logic [3:0] result_o,
    output logic       done_o,
    output logic       busy_o,
    output logic       aborted_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PAD,
        SETTLE,
        RUN,
        SAMPLE
    } state_t;

    localparam logic [4:0] DEPTH_C = 5'(DEPTH);
    localparam logic [4:0] LAST_C  = 5'(DEPTH - 1);

    state_t     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic [4:0] count_q, count_d;
    logic [7:0] run_len_q, run_len_d;
    logic [8:0] run_cnt_q, run_cnt_d;
    logic [3:0] addr_q, addr_d;
    logic [7:0] ins_q, ins_d;
    logic [3:0] din_q, din_d;
    logic [3:0] result_q, result_d;
    logic       aborted_q, aborted_d;
    logic [4:0] count_clamped;
    logic [4:0] idx_inc;

    assign count_clamped = (load_count_i > DEPTH_C) ? DEPTH_C : load_count_i;
    assign idx_inc       = idx_q + 5'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            count_q   <= '0;
            run_len_q <= '0;
            run_cnt_q <= '0;
            addr_q    <= '0;
            ins_q     <= '0;
            din_q     <= '0;
            result_q  <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            run_len_q <= run_len_d;
            run_cnt_q <= run_cnt_d;
            addr_q    <= addr_d;
            ins_q     <= ins_d;
            din_q     <= din_d;
            result_q  <= result_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        count_d    = count_q;
        run_len_d  = run_len_q;
        run_cnt_d  = run_cnt_q;
        addr_d     = addr_q;
        ins_d      = ins_q;
        din_d      = din_q;
        result_d   = result_q;
        aborted_d  = aborted_q;
        wr_ready_o = (state_q == LOAD) && !abort_i;

        // Abort in any active state drops straight back to IDLE; write pins keep their last values.
        if (abort_i && (state_q inside {LOAD, PAD, SETTLE, RUN})) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        count_d   = count_clamped;
                        run_len_d = run_len_i;
                        idx_d     = '0;
                        aborted_d = 1'b0;
                        state_d   = (count_clamped != 5'd0) ? LOAD : PAD;
                    end
                end
                LOAD: begin
                    if (wr_valid_i) begin
                        addr_d = idx_q[3:0];
                        ins_d  = wr_ins_i;
                        din_d  = wr_data_i;
                        idx_d  = idx_inc;
                        if (idx_inc == count_q) begin
                            state_d = (count_q == DEPTH_C) ? SETTLE : PAD;
                        end
                    end
                end
                PAD: begin
                    addr_d = idx_q[3:0];
                    ins_d  = PAD_INS;
                    din_d  = PAD_DATA;
                    idx_d  = idx_inc;
                    if (idx_q == LAST_C) begin
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    run_cnt_d = (run_len_q == 8'd0) ? 9'd256 : {1'b0, run_len_q};
                    state_d   = RUN;
                end
                RUN: begin
                    if (run_cnt_q == 9'd1) begin
                        result_d = cpu_d_out_i;
                        state_d  = SAMPLE;
                    end else begin
                        run_cnt_d = run_cnt_q - 9'd1;
                    end
                end
                SAMPLE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign cpu_ins_address_o = addr_q;
    assign cpu_ins_o         = ins_q;
    assign cpu_d_in_o        = din_q;
    assign cpu_rst_o         = (state_q != RUN);
    assign result_o          = result_q;
    assign done_o            = (state_q == SAMPLE);
    assign busy_o            = (state_q != IDLE);
    assign aborted_o         = aborted_q;

endmodule

// File: tb/tb_cpu4_program_sequencer.sv
// tb/tb_cpu4_program_sequencer.sv - directed table-driven bench for cpu4_program_sequencer
module tb_cpu4_program_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [4:0] load_count_i = '0;
    logic [7:0] run_len_i = '0;
    logic       wr_valid_i = 1'b0;
    logic       wr_ready_o;
    logic [7:0] wr_ins_i = '0;
    logic [3:0] wr_data_i = '0;
    logic [3:0] cpu_ins_address_o;
    logic [7:0] cpu_ins_o;
    logic [3:0] cpu_d_in_o;
    logic       cpu_rst_o;
    logic [3:0] cpu_d_out_i;
    logic [3:0] result_o;
    logic       done_o;
    logic       busy_o;
    logic       aborted_o;

    logic [3:0]  dout_val = 4'h0;
    logic [11:0] mem [16];
    int          n_checks = 0;
    int          n_pass = 0;

    typedef struct {
        logic [4:0] lc;
        logic [7:0] rl;
        logic [7:0] vmask;
        logic [3:0] dout;
        int         start_at;
        int         exp_done;
        int         exp_low;
    } vec_t;

    vec_t vecs[6];

    cpu4_program_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .load_count_i(load_count_i), .run_len_i(run_len_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .wr_ins_i(wr_ins_i), .wr_data_i(wr_data_i),
        .cpu_ins_address_o(cpu_ins_address_o), .cpu_ins_o(cpu_ins_o),
        .cpu_d_in_o(cpu_d_in_o), .cpu_rst_o(cpu_rst_o),
        .cpu_d_out_i(cpu_d_out_i), .result_o(result_o), .done_o(done_o),
        .busy_o(busy_o), .aborted_o(aborted_o)
    );

    always #5 clk_i = ~clk_i;

    // Stand-in CPU: drives a fixed value only while released from reset, and stores each negedge write.
    assign cpu_d_out_i = cpu_rst_o ? 4'h0 : dout_val;

    always @(negedge clk_i) begin
        if (busy_o) mem[cpu_ins_address_o] = {cpu_ins_o, cpu_d_in_o};
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] beat_ins(input int i);
        logic [3:0] ii;
        ii = i[3:0];
        case (i)
            0: return 8'h17;
            1: return 8'h00;
            2: return 8'h04;
            default: return {ii, 4'h3};
        endcase
    endfunction

    function automatic logic [3:0] beat_data(input int i);
        logic [3:0] ii;
        ii = i[3:0];
        return (i < 3) ? 4'h0 : (ii ^ 4'hA);
    endfunction

    task automatic run_vec(input vec_t v, input int k);
        int nb, bi, n, done_n, dcnt, low, bad;
        logic acc, offer;
        nb = (v.lc > 5'd16) ? 16 : int'(v.lc);
        for (int j = 0; j < 16; j++) mem[j] = 12'hABC;
        dout_val = v.dout;
        start_i = 1'b1;
        load_count_i = v.lc;
        run_len_i = v.rl;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check($sformatf("v%0d_aborted_clear", k), aborted_o, 0);
        check($sformatf("v%0d_busy", k), busy_o, 1);
        n = 1; bi = 0; done_n = 0; dcnt = 0; low = 0;
        while (n < 400 && !(done_n != 0 && n > done_n + 2)) begin
            offer = (bi < nb) && ((n - 1) >= 8 || v.vmask[(n - 1) % 8]);
            wr_valid_i = offer;
            wr_ins_i = beat_ins(bi);
            wr_data_i = beat_data(bi);
            start_i = (n == v.start_at);
            acc = offer && wr_ready_o;
            @(posedge clk_i); #1;
            n++;
            if (acc) bi++;
            if (!cpu_rst_o) low++;
            if (done_o) begin
                dcnt++;
                if (done_n == 0) done_n = n;
            end
        end
        wr_valid_i = 1'b0;
        start_i = 1'b0;
        check($sformatf("v%0d_done_cycle", k), done_n, v.exp_done);
        check($sformatf("v%0d_done_count", k), dcnt, 1);
        check($sformatf("v%0d_rst_low_cycles", k), low, v.exp_low);
        check($sformatf("v%0d_result", k), result_o, v.dout);
        check($sformatf("v%0d_beats", k), bi, nb);
        check($sformatf("v%0d_idle", k), busy_o, 0);
        bad = 0;
        for (int j = 0; j < 16; j++) begin
            if (mem[j] != ((j < nb) ? {beat_ins(j), beat_data(j)} : 12'h0F0)) bad++;
        end
        check($sformatf("v%0d_mem_slots_bad", k), bad, 0);
    endtask

    initial begin
        int dcnt;
        vecs[0] = '{lc: 5'd3,  rl: 8'd10, vmask: 8'hFF, dout: 4'h1, start_at: -1,  exp_done: 28,  exp_low: 10};
        vecs[1] = '{lc: 5'd3,  rl: 8'd10, vmask: 8'hE9, dout: 4'h1, start_at: -1,  exp_done: 31,  exp_low: 10};
        vecs[2] = '{lc: 5'd16, rl: 8'd5,  vmask: 8'hFF, dout: 4'h9, start_at: -1,  exp_done: 23,  exp_low: 5};
        vecs[3] = '{lc: 5'd20, rl: 8'd5,  vmask: 8'hFF, dout: 4'h6, start_at: -1,  exp_done: 23,  exp_low: 5};
        vecs[4] = '{lc: 5'd0,  rl: 8'd1,  vmask: 8'hFF, dout: 4'hC, start_at: -1,  exp_done: 19,  exp_low: 1};
        vecs[5] = '{lc: 5'd3,  rl: 8'd0,  vmask: 8'hFF, dout: 4'h1, start_at: 100, exp_done: 274, exp_low: 256};

        // Reset, with start held high to show reset wins.
        rst_i = 1'b1;
        start_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_cpu_rst", cpu_rst_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_wr_ready", wr_ready_o, 0);
        check("rst_result", result_o, 0);
        check("rst_addr", cpu_ins_address_o, 0);
        check("rst_ins", cpu_ins_o, 0);
        check("rst_din", cpu_d_in_o, 0);
        check("rst_aborted", aborted_o, 0);
        start_i = 1'b0;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        run_vec(vecs[0], 0);

        // Abort while the second beat is offered.
        start_i = 1'b1;
        load_count_i = 5'd3;
        run_len_i = 8'd10;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        wr_valid_i = 1'b1;
        wr_ins_i = 8'h17;
        wr_data_i = 4'h0;
        @(posedge clk_i); #1;
        wr_ins_i = 8'h00;
        abort_i = 1'b1;
        #1;
        check("abort_wr_ready", wr_ready_o, 0);
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        wr_valid_i = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_aborted", aborted_o, 1);
        check("abort_cpu_rst", cpu_rst_o, 1);
        check("abort_addr", cpu_ins_address_o, 0);
        check("abort_ins", cpu_ins_o, 8'h17);
        check("abort_result", result_o, 1);
        dcnt = 0;
        repeat (5) begin
            @(posedge clk_i); #1;
            if (done_o) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        check("abort_sticky", aborted_o, 1);

        // Reset mid-load clears everything, including the sticky flag.
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check("restart_aborted_clear", aborted_o, 0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("midrst_busy", busy_o, 0);
        check("midrst_aborted", aborted_o, 0);
        check("midrst_ins", cpu_ins_o, 0);
        check("midrst_result", result_o, 0);

        for (int k = 1; k < 6; k++) run_vec(vecs[k], k);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
